// File: rtl/dmem_access_unit.sv
// Memory-stage sequencer: turns EX load/store requests into a req/ready, rvalid
// data-memory transaction, stalling the pipeline while an access is outstanding.
module dmem_access_unit #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic                  ex_is_store,
  input  logic [1:0]            ex_size,
  input  logic [31:0]           ex_addr,
  input  logic [31:0]           ex_store_data,
  output logic                  mem_req,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  stall,
  output logic [31:0]           wb_dmem_data,
  output logic                  wb_load_done,
  output logic                  store_done,
  output logic                  misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} state_t;

  typedef struct packed {
    logic                  req;
    logic [3:0]            we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
  } mem_req_t;

  state_t   state, state_nx;
  mem_req_t mreq, mreq_nx;
  logic     cur_store, cur_store_nx;
  logic [31:0] rdata_nx;
  logic     load_done_nx, store_done_nx, misalign_nx;
  logic     accept, aligned;
  logic     unused_addr_hi;

  // Upper address bits fall outside the memory and are deliberately dropped.
  assign unused_addr_hi = ^ex_addr[31:ADDR_WIDTH+2];

  assign accept = ex_valid & (ex_is_load | ex_is_store);
  assign stall  = (state != IDLE);

  always_comb begin
    case (ex_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~ex_addr[0];
      2'b10:   aligned = (ex_addr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mreq         <= '0;
      cur_store    <= 1'b0;
      wb_dmem_data <= '0;
      wb_load_done <= 1'b0;
      store_done   <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nx;
      mreq         <= mreq_nx;
      cur_store    <= cur_store_nx;
      wb_dmem_data <= rdata_nx;
      wb_load_done <= load_done_nx;
      store_done   <= store_done_nx;
      misalign_err <= misalign_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && aligned) state_nx = REQ;
      REQ:     if (mem_ready) state_nx = cur_store ? IDLE : WAIT_RD;
      WAIT_RD: if (mem_rvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mreq_nx       = mreq;
    cur_store_nx  = cur_store;
    rdata_nx      = wb_dmem_data;
    load_done_nx  = 1'b0;
    store_done_nx = 1'b0;
    misalign_nx   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (!aligned) begin
          misalign_nx = 1'b1;
        end else begin
          mreq_nx.req  = 1'b1;
          mreq_nx.addr = ex_addr[ADDR_WIDTH+1:2];
          cur_store_nx = ex_is_store;
          mreq_nx.we    = 4'b0000;
          mreq_nx.wdata = '0;
          // Store wins when both load and store are flagged.
          if (ex_is_store) begin
            case (ex_size)
              2'b00: begin
                mreq_nx.we    = 4'b0001 << ex_addr[1:0];
                mreq_nx.wdata = {4{ex_store_data[7:0]}};
              end
              2'b01: begin
                mreq_nx.we    = 4'b0011 << {ex_addr[1], 1'b0};
                mreq_nx.wdata = {2{ex_store_data[15:0]}};
              end
              default: begin
                mreq_nx.we    = 4'b1111;
                mreq_nx.wdata = ex_store_data;
              end
            endcase
          end
        end
      end
      REQ: if (mem_ready) begin
        mreq_nx.req = 1'b0;
        if (cur_store) begin
          mreq_nx.we    = 4'b0000;
          store_done_nx = 1'b1;
        end
      end
      WAIT_RD: if (mem_rvalid) begin
        rdata_nx     = mem_rdata;
        load_done_nx = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_req   = mreq.req;
  assign mem_we    = mreq.we;
  assign mem_addr  = mreq.addr;
  assign mem_wdata = mreq.wdata;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Scenario bench for dmem_access_unit with a randomized arithmetic reference model.
module tb_dmem_access_unit;
  localparam int AW = 14;

  logic clk = 0, rst_n = 0;
  logic ex_valid = 0, ex_is_load = 0, ex_is_store = 0;
  logic [1:0] ex_size = 0;
  logic [31:0] ex_addr = 0, ex_store_data = 0;
  logic mem_req;
  logic [3:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic mem_ready = 0, mem_rvalid = 0;
  logic [31:0] mem_rdata = 0;
  logic stall, wb_load_done, store_done, misalign_err;
  logic [31:0] wb_dmem_data;

  int checks = 0, errors = 0;

  dmem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_size(ex_size), .ex_addr(ex_addr),
    .ex_store_data(ex_store_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall(stall),
    .wb_dmem_data(wb_dmem_data), .wb_load_done(wb_load_done),
    .store_done(store_done), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Reference: byte lanes from arithmetic on the byte offset.
  function automatic logic [3:0] ref_we(input logic st, input int sz, input int off);
    if (!st) return 4'h0;
    if (sz == 0) return 4'(1 << off);
    if (sz == 1) return 4'(3 << ((off / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic st, input int sz, input logic [31:0] d);
    if (!st) return 32'h0;
    if (sz == 0) return (d % 256) * 32'h0101_0101;
    if (sz == 1) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic ref_mis(input int sz, input int off);
    return (sz == 3) || (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
  endfunction

  task automatic present(input logic ld, input logic st, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
    ex_valid = 1; ex_is_load = ld; ex_is_store = st; ex_size = sz;
    ex_addr = a; ex_store_data = d;
  endtask

  task automatic test_reset;
    rst_n = 0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req); end
    checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL reset_we got %h exp 0", mem_we); end
    checks++; if (mem_addr !== '0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_addr_wdata got %h %h exp 0", mem_addr, mem_wdata); end
    checks++; if (wb_dmem_data !== 32'h0) begin errors++; $display("FAIL reset_wbdata got %h exp 0", wb_dmem_data); end
    checks++; if ({stall, wb_load_done, store_done, misalign_err} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {stall, wb_load_done, store_done, misalign_err}); end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_store_byte;
    present(0, 1, 2'b00, 32'h1003, 32'hDEADBEEF); mem_ready = 1;
    @(negedge clk); ex_valid = 0;
    checks++; if (mem_req !== 1 || mem_we !== 4'b1000) begin errors++; $display("FAIL sb_req_we got %b %b exp 1 1000", mem_req, mem_we); end
    checks++; if (mem_wdata !== 32'hEFEFEFEF || mem_addr !== 14'h400) begin errors++; $display("FAIL sb_data_addr got %h %h exp efefefef 400", mem_wdata, mem_addr); end
    checks++; if (stall !== 1 || store_done !== 0) begin errors++; $display("FAIL sb_stall1 got %b %b exp 1 0", stall, store_done); end
    @(negedge clk);
    checks++; if (store_done !== 1 || stall !== 0 || mem_req !== 0 || mem_we !== 0) begin errors++; $display("FAIL sb_done got done=%b stall=%b req=%b we=%b exp 1 0 0 0", store_done, stall, mem_req, mem_we); end
    mem_ready = 0;
    @(negedge clk);
    checks++; if (store_done !== 0) begin errors++; $display("FAIL sb_pulse got %b exp 0", store_done); end
  endtask

  task automatic test_word_load;
    int pulses = 0;
    present(1, 0, 2'b10, 32'h20, 32'h0);
    @(negedge clk); ex_valid = 0;
    checks++; if (mem_req !== 1 || mem_we !== 4'h0 || mem_addr !== 14'h8) begin errors++; $display("FAIL wl_req got req=%b we=%b addr=%h exp 1 0 8", mem_req, mem_we, mem_addr); end
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1 || mem_addr !== 14'h8 || stall !== 1) begin errors++; $display("FAIL wl_hold got req=%b addr=%h stall=%b", mem_req, mem_addr, stall); end
    mem_ready = 1;
    @(negedge clk); mem_ready = 0;
    checks++; if (mem_req !== 0 || stall !== 1) begin errors++; $display("FAIL wl_waitrd got req=%b stall=%b exp 0 1", mem_req, stall); end
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'h12345678;
    @(negedge clk); mem_rvalid = 0; mem_rdata = 32'hFFFF_FFFF;
    if (wb_load_done) pulses++;
    checks++; if (wb_dmem_data !== 32'h12345678 || stall !== 0) begin errors++; $display("FAIL wl_data got %h stall=%b exp 12345678 0", wb_dmem_data, stall); end
    @(negedge clk);
    if (wb_load_done) pulses++;
    checks++; if (pulses != 1 || wb_dmem_data !== 32'h12345678) begin errors++; $display("FAIL wl_pulse got pulses=%0d data=%h exp 1 12345678", pulses, wb_dmem_data); end
  endtask

  task automatic test_misaligned;
    logic [1:0]  sz [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] ad [3] = '{32'h101, 32'h102, 32'h100};
    for (int i = 0; i < 3; i++) begin
      present(i == 1, i != 1, sz[i], ad[i], 32'h5555_AAAA);
      @(negedge clk); ex_valid = 0;
      checks++; if (misalign_err !== 1 || mem_req !== 0 || stall !== 0) begin errors++; $display("FAIL mis%0d got err=%b req=%b stall=%b exp 1 0 0", i, misalign_err, mem_req, stall); end
      @(negedge clk);
      checks++; if (misalign_err !== 0 || mem_req !== 0 || stall !== 0) begin errors++; $display("FAIL mis%0d_after got err=%b req=%b stall=%b exp 0 0 0", i, misalign_err, mem_req, stall); end
    end
  endtask

  task automatic test_half_store;
    present(0, 1, 2'b01, 32'h6, 32'h0000ABCD); mem_ready = 1;
    @(negedge clk); ex_valid = 0;
    checks++; if (mem_we !== 4'b1100 || mem_wdata !== 32'hABCDABCD || mem_addr !== 14'h1) begin errors++; $display("FAIL hs got we=%b wdata=%h addr=%h exp 1100 abcdabcd 1", mem_we, mem_wdata, mem_addr); end
    @(negedge clk); mem_ready = 0;
    checks++; if (store_done !== 1) begin errors++; $display("FAIL hs_done got %b exp 1", store_done); end
  endtask

  task automatic test_back_to_back;
    present(0, 1, 2'b10, 32'h40, 32'hCAFEF00D); mem_ready = 1;
    @(negedge clk);
    present(1, 0, 2'b10, 32'h44, 32'h0);
    @(negedge clk);
    checks++; if (store_done !== 1 || stall !== 0 || mem_req !== 0) begin errors++; $display("FAIL b2b_store got done=%b stall=%b req=%b exp 1 0 0", store_done, stall, mem_req); end
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk); ex_valid = 0;
    checks++; if (mem_req !== 1 || mem_we !== 0 || mem_addr !== 14'h11 || stall !== 1) begin errors++; $display("FAIL b2b_load_req got req=%b we=%b addr=%h stall=%b exp 1 0 11 1", mem_req, mem_we, mem_addr, stall); end
    @(negedge clk);
    checks++; if (wb_load_done !== 0 || mem_req !== 1) begin errors++; $display("FAIL b2b_rvalid_ignored got done=%b req=%b exp 0 1", wb_load_done, mem_req); end
    mem_ready = 1; mem_rvalid = 0;
    @(negedge clk); mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0BADCAFE;
    @(negedge clk); mem_rvalid = 0;
    checks++; if (wb_load_done !== 1 || wb_dmem_data !== 32'h0BADCAFE) begin errors++; $display("FAIL b2b_load_done got done=%b data=%h exp 1 0badcafe", wb_load_done, wb_dmem_data); end
  endtask

  task automatic test_reset_mid_load;
    present(1, 0, 2'b00, 32'h77, 32'h0); mem_ready = 1;
    @(negedge clk); ex_valid = 0;
    @(negedge clk); mem_ready = 0;
    checks++; if (stall !== 1 || mem_req !== 0) begin errors++; $display("FAIL rml_inwait got stall=%b req=%b exp 1 0", stall, mem_req); end
    #2 rst_n = 0; mem_rvalid = 1; mem_rdata = 32'h99999999;
    #1;
    checks++; if (mem_req !== 0 || stall !== 0 || wb_dmem_data !== 0 || wb_load_done !== 0) begin errors++; $display("FAIL rml_reset got req=%b stall=%b data=%h done=%b exp 0 0 0 0", mem_req, stall, wb_dmem_data, wb_load_done); end
    @(negedge clk); rst_n = 1;
    @(negedge clk); mem_rvalid = 0;
    checks++; if (wb_load_done !== 0 || stall !== 0 || wb_dmem_data !== 0) begin errors++; $display("FAIL rml_after got done=%b stall=%b data=%h exp 0 0 0", wb_load_done, stall, wb_dmem_data); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 60; it++) begin
      int kind = $urandom_range(0, 9);
      logic ld = (kind < 4) || (kind == 8);
      logic st = (kind >= 4 && kind < 8) || (kind == 8);
      int sz = $urandom_range(0, 3);
      logic [31:0] a = $urandom, d = $urandom, rd = $urandom;
      int off = a % 4;
      int rdy_dly = $urandom_range(0, 3), rv_dly = $urandom_range(0, 3);
      present(ld, st, 2'(sz), a, d);
      @(negedge clk); ex_valid = 0;
      if (!ld && !st) begin
        checks++; if (mem_req !== 0 || misalign_err !== 0 || stall !== 0) begin errors++; $display("FAIL rnd%0d_noop got req=%b err=%b stall=%b exp 0 0 0", it, mem_req, misalign_err, stall); end
      end else if (ref_mis(sz, off)) begin
        checks++; if (misalign_err !== 1 || mem_req !== 0 || stall !== 0) begin errors++; $display("FAIL rnd%0d_mis got err=%b req=%b stall=%b exp 1 0 0", it, misalign_err, mem_req, stall); end
      end else begin
        checks++; if (mem_req !== 1 || mem_we !== ref_we(st, sz, off) || mem_wdata !== ref_wdata(st, sz, d) || mem_addr !== a[AW+1:2]) begin
          errors++; $display("FAIL rnd%0d_req got req=%b we=%b wd=%h ad=%h exp 1 %b %h %h", it, mem_req, mem_we, mem_wdata, mem_addr, ref_we(st, sz, off), ref_wdata(st, sz, d), a[AW+1:2]);
        end
        repeat (rdy_dly) @(negedge clk);
        mem_ready = 1;
        @(negedge clk); mem_ready = 0;
        if (st) begin
          checks++; if (store_done !== 1 || stall !== 0) begin errors++; $display("FAIL rnd%0d_st got done=%b stall=%b exp 1 0", it, store_done, stall); end
        end else begin
          repeat (rv_dly) @(negedge clk);
          mem_rvalid = 1; mem_rdata = rd;
          @(negedge clk); mem_rvalid = 0;
          checks++; if (wb_load_done !== 1 || wb_dmem_data !== rd || stall !== 0) begin errors++; $display("FAIL rnd%0d_ld got done=%b data=%h stall=%b exp 1 %h 0", it, wb_load_done, wb_dmem_data, stall, rd); end
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_word_load();
    test_misaligned();
    test_half_store();
    test_back_to_back();
    test_reset_mid_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout after 500000 time units");
    $fatal(1);
  end
endmodule
